// File: rtl/ddr_sched_pkg.sv
// ddr_sched_pkg: shared types for the DDR read/write burst scheduler.
// Holds the FSM state enum, grant direction enum and default timing lengths.
package ddr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR_ACT,
    RD_ACT,
    TURN
  } state_t;

  typedef enum logic {
    WRITE,
    READ
  } dir_t;

  localparam int DEF_TURN_CYC    = 2;
  localparam int DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/ddr_sched_watchdog.sv
// ddr_sched_watchdog: no-progress counter; clk, rst_n (async, high), clr, en in;
// expire out pulses on the cycle the idle count reaches TIMEOUT_CYC-1.
module ddr_sched_watchdog
  import ddr_sched_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 2);

  logic [CW-1:0] cnt;

  // Fires while the count is about to step onto TIMEOUT_CYC-1.
  assign expire = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt <= '0;
    end else if (clr || !en || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ddr_rw_scheduler.sv
// ddr_rw_scheduler: grants the DDR port to one write or read burst at a time.
// Ports: w/r request handshakes, DDR busy/beat inputs, grants, done, stats.
module ddr_rw_scheduler
  import ddr_sched_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int BEATS_W     = 9,
  parameter int TURN_CYC    = DEF_TURN_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wreq_valid,
  input  logic [ADDR_WIDTH-1:0] wreq_addr,
  input  logic [7:0]            wreq_len,
  output logic                  wreq_ready,
  input  logic                  rreq_valid,
  input  logic [ADDR_WIDTH-1:0] rreq_addr,
  input  logic [7:0]            rreq_len,
  output logic                  rreq_ready,
  input  logic                  wr_busy,
  input  logic                  rd_busy,
  input  logic                  wr_ack,
  input  logic                  rd_valid,
  output logic                  wr_grant,
  output logic                  rd_grant,
  output logic [ADDR_WIDTH-1:0] gnt_addr,
  output logic                  wr_done,
  output logic                  rd_done,
  output logic                  timeout_err,
  output logic [CNT_WIDTH-1:0]  wr_burst_cnt,
  output logic [CNT_WIDTH-1:0]  rd_burst_cnt
);

  localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);

  state_t             state;
  dir_t               last_dir;
  dir_t               new_dir;
  logic [BEATS_W-1:0] beats;
  logic [TW-1:0]      tcnt;
  logic [7:0]         len_sel;

  logic idle;
  logic w_el;
  logic r_el;
  logic pick_w;
  logic pick_r;
  logic act_w;
  logic act_r;
  logic beat;
  logic last_beat;
  logic expire;

  // Ready is combinational so the handshake completes in the IDLE cycle;
  // gated by reset so no output is high while reset is asserted.
  assign idle   = (state == IDLE) && !rst_n;
  assign w_el   = wreq_valid && !wr_busy;
  assign r_el   = rreq_valid && !rd_busy;
  assign pick_w = idle && w_el && (!r_el || last_dir == READ);
  assign pick_r = idle && r_el && !pick_w;

  assign wreq_ready = pick_w;
  assign rreq_ready = pick_r;

  assign new_dir = pick_w ? WRITE : READ;
  assign len_sel = pick_w ? wreq_len : rreq_len;

  assign act_w = (state == WR_ACT);
  assign act_r = (state == RD_ACT);

  // Only beats of the owning direction count, and never past zero.
  assign beat = ((act_w && wr_ack) || (act_r && rd_valid))
             && (beats != '0);
  assign last_beat = beat && (beats == BEATS_W'(1));

  assign wr_done     = act_w && last_beat;
  assign rd_done     = act_r && last_beat;
  assign timeout_err = expire;

  ddr_sched_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (beat),
    .en    (act_w || act_r),
    .expire(expire)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state        <= IDLE;
      last_dir     <= READ;
      beats        <= '0;
      tcnt         <= '0;
      gnt_addr     <= '0;
      wr_grant     <= 1'b0;
      rd_grant     <= 1'b0;
      wr_burst_cnt <= '0;
      rd_burst_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_w || pick_r) begin
            gnt_addr <= pick_w ? wreq_addr : rreq_addr;
            beats    <= BEATS_W'(len_sel) + BEATS_W'(1);
            last_dir <= new_dir;
            tcnt     <= '0;
            if (TURN_CYC != 0 && new_dir != last_dir) begin
              state <= TURN;
            end else begin
              state    <= pick_w ? WR_ACT : RD_ACT;
              wr_grant <= pick_w;
              rd_grant <= pick_r;
            end
          end
        end
        TURN: begin
          // last_dir already names the pending burst.
          if (tcnt == TURN_LAST) begin
            state    <= (last_dir == WRITE) ? WR_ACT : RD_ACT;
            wr_grant <= (last_dir == WRITE);
            rd_grant <= (last_dir == READ);
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        WR_ACT, RD_ACT: begin
          if (beat) begin
            beats <= beats - BEATS_W'(1);
          end
          if (last_beat || expire) begin
            state    <= IDLE;
            wr_grant <= 1'b0;
            rd_grant <= 1'b0;
          end
          if (wr_done && wr_burst_cnt != '1) begin
            wr_burst_cnt <= wr_burst_cnt + CNT_WIDTH'(1);
          end
          if (rd_done && rd_burst_cnt != '1) begin
            rd_burst_cnt <= rd_burst_cnt + CNT_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_grant_excl: assert property (
    @(posedge clk) disable iff (rst_n) !(wr_grant && rd_grant)
  );

endmodule

// File: tb/tb_ddr_rw_scheduler.sv
// tb_ddr_rw_scheduler: directed stimulus with an event scoreboard.
// Expected events and their cycle spacing are queued; a monitor checks them.
module tb_ddr_rw_scheduler;

  localparam int AW = 32;
  localparam int TC = 2;
  localparam int TO = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wreq_valid, rreq_valid;
  logic [AW-1:0] wreq_addr, rreq_addr;
  logic [7:0]    wreq_len, rreq_len;
  logic          wreq_ready, rreq_ready;
  logic          wr_busy, rd_busy, wr_ack, rd_valid;
  logic          wr_grant, rd_grant;
  logic [AW-1:0] gnt_addr;
  logic          wr_done, rd_done, timeout_err;
  logic [CW-1:0] wr_burst_cnt, rd_burst_cnt;

  ddr_rw_scheduler #(
    .ADDR_WIDTH (AW),
    .BEATS_W    (9),
    .TURN_CYC   (TC),
    .TIMEOUT_CYC(TO),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wreq_valid  (wreq_valid),
    .wreq_addr   (wreq_addr),
    .wreq_len    (wreq_len),
    .wreq_ready  (wreq_ready),
    .rreq_valid  (rreq_valid),
    .rreq_addr   (rreq_addr),
    .rreq_len    (rreq_len),
    .rreq_ready  (rreq_ready),
    .wr_busy     (wr_busy),
    .rd_busy     (rd_busy),
    .wr_ack      (wr_ack),
    .rd_valid    (rd_valid),
    .wr_grant    (wr_grant),
    .rd_grant    (rd_grant),
    .gnt_addr    (gnt_addr),
    .wr_done     (wr_done),
    .rd_done     (rd_done),
    .timeout_err (timeout_err),
    .wr_burst_cnt(wr_burst_cnt),
    .rd_burst_cnt(rd_burst_cnt)
  );

  always #5 clk = ~clk;

  typedef enum int {
    EV_WACC, EV_RACC, EV_WGNT, EV_RGNT,
    EV_WDONE, EV_RDONE, EV_TO
  } ev_t;

  typedef struct {
    ev_t           kind;
    logic [AW-1:0] addr;
    int            delta;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input ev_t k, input logic [AW-1:0] a, input int d);
    exp_t e;
    e.kind  = k;
    e.addr  = a;
    e.delta = d;
    q.push_back(e);
  endtask

  task automatic see(input ev_t k);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected event %s at cycle %0d", k.name(), cyc);
    end else begin
      e = q.pop_front();
      checks++;
      if (k != e.kind) begin
        errors++;
        $display("FAIL event order: got %s expected %s at cycle %0d",
                 k.name(), e.kind.name(), cyc);
      end
      if (k == EV_WGNT || k == EV_RGNT)
        chk({"gnt_addr at ", k.name()}, gnt_addr, e.addr);
      if (e.delta >= 0)
        chk({"spacing before ", k.name()}, cyc - last_cyc, e.delta);
      last_cyc = cyc;
    end
  endtask

  // Monitor: samples on the falling edge, away from input changes.
  initial begin
    logic pw, pr;
    pw = 1'b0;
    pr = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        pw = 1'b0;
        pr = 1'b0;
      end else begin
        if (wreq_ready) see(EV_WACC);
        if (rreq_ready) see(EV_RACC);
        if (wr_grant && !pw) see(EV_WGNT);
        if (rd_grant && !pr) see(EV_RGNT);
        if (wr_done) see(EV_WDONE);
        if (rd_done) see(EV_RDONE);
        if (timeout_err) see(EV_TO);
        pw = wr_grant;
        pr = rd_grant;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit w, input logic [AW-1:0] a,
                     input logic [7:0] len, output int lat);
    lat = -1;
    if (w) begin
      wreq_valid = 1'b1; wreq_addr = a; wreq_len = len;
    end else begin
      rreq_valid = 1'b1; rreq_addr = a; rreq_len = len;
    end
    for (int i = 0; i < 100; i++) begin
      #1;
      if ((w && wreq_ready) || (!w && rreq_ready)) begin
        lat = i;
        break;
      end
      tick();
    end
    tick();
    if (w) wreq_valid = 1'b0;
    else rreq_valid = 1'b0;
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL request handshake: got none expected ready");
    end
  endtask

  task automatic wait_grant(input bit w);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if ((w && wr_grant) || (!w && rd_grant)) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL grant wait: got no grant expected one");
    end
  endtask

  task automatic send(input bit w, input int n);
    for (int i = 0; i < n; i++) begin
      if (w) wr_ack = 1'b1;
      else rd_valid = 1'b1;
      tick();
    end
    wr_ack   = 1'b0;
    rd_valid = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    wreq_valid = 0; rreq_valid = 0;
    wreq_addr = '0; rreq_addr = '0;
    wreq_len = '0; rreq_len = '0;
    wr_busy = 0; rd_busy = 0; wr_ack = 0; rd_valid = 0;

    // Reset state, with a write request already pending.
    wreq_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst wreq_ready", wreq_ready, 0);
    chk("rst wr_grant", wr_grant, 0);
    chk("rst rd_grant", rd_grant, 0);
    chk("rst gnt_addr", gnt_addr, 0);
    chk("rst done/timeout", {wr_done, rd_done, timeout_err}, 0);
    chk("rst wr_burst_cnt", wr_burst_cnt, 0);
    chk("rst rd_burst_cnt", rd_burst_cnt, 0);
    wreq_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();

    // Single write len=3; READ->WRITE change inserts the turnaround.
    push(EV_WACC, '0, -1);
    push(EV_WGNT, 32'h1000, TC + 1);
    push(EV_WDONE, '0, 3);
    req(1'b1, 32'h1000, 8'd3, lat);
    wait_grant(1'b1);
    send(1'b1, 4);
    chk("s1 wr_burst_cnt", wr_burst_cnt, 1);

    // Same-direction write: grant next cycle; spurious rd_valid and
    // an extra ack after the last beat must not disturb anything.
    push(EV_WACC, '0, 1);
    push(EV_WGNT, 32'h2000, 1);
    push(EV_WDONE, '0, 2);
    req(1'b1, 32'h2000, 8'd2, lat);
    rd_valid = 1'b1;
    wait_grant(1'b1);
    send(1'b1, 4);
    chk("s1b wr_grant low", wr_grant, 0);
    chk("s1b wr_burst_cnt", wr_burst_cnt, 2);
    chk("s1b rd_burst_cnt", rd_burst_cnt, 0);

    // Read blocked by rd_busy for 10 cycles.
    push(EV_RACC, '0, -1);
    push(EV_RGNT, 32'h3000, TC + 1);
    push(EV_RDONE, '0, 1);
    fork
      begin
        rd_busy = 1'b1;
        repeat (10) tick();
        rd_busy = 1'b0;
      end
      req(1'b0, 32'h3000, 8'd1, lat);
    join
    chk("s3 busy latency", lat, 10);
    wait_grant(1'b0);
    send(1'b0, 2);
    chk("s3 rd_burst_cnt", rd_burst_cnt, 1);

    // Watchdog: 3 of 8 beats, then silence.
    push(EV_WACC, '0, 1);
    push(EV_WGNT, 32'h4000, TC + 1);
    push(EV_TO, '0, 2 + (TO - 1));
    req(1'b1, 32'h4000, 8'd7, lat);
    wait_grant(1'b1);
    send(1'b1, 3);
    repeat (18) tick();
    chk("s4 wr_grant dropped", wr_grant, 0);
    chk("s4 wr_burst_cnt kept", wr_burst_cnt, 2);
    chk("s4 events drained", q.size(), 0);

    // Reset in the middle of a read burst.
    push(EV_RACC, '0, -1);
    push(EV_RGNT, 32'h5000, TC + 1);
    req(1'b0, 32'h5000, 8'd3, lat);
    wait_grant(1'b0);
    send(1'b0, 1);
    chk("s5 rd_grant before reset", rd_grant, 1);
    rst_n = 1'b1;
    #1;
    chk("s5 rd_grant in reset", rd_grant, 0);
    chk("s5 wr_burst_cnt in reset", wr_burst_cnt, 0);
    chk("s5 rd_burst_cnt in reset", rd_burst_cnt, 0);
    tick();
    rst_n = 1'b0;
    tick();

    // Both requesters held: W,R,W,R, write first after reset.
    push(EV_WACC, '0, -1);
    push(EV_WGNT, 32'h6000, TC + 1);
    push(EV_WDONE, '0, 0);
    push(EV_RACC, '0, 1);
    push(EV_RGNT, 32'h7000, TC + 1);
    push(EV_RDONE, '0, 0);
    push(EV_WACC, '0, 1);
    push(EV_WGNT, 32'h6000, TC + 1);
    push(EV_WDONE, '0, 0);
    push(EV_RACC, '0, 1);
    push(EV_RGNT, 32'h7000, TC + 1);
    push(EV_RDONE, '0, 0);
    wreq_addr = 32'h6000; wreq_len = 8'd0;
    rreq_addr = 32'h7000; rreq_len = 8'd0;
    wreq_valid = 1'b1;
    rreq_valid = 1'b1;
    n = 0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          wr_ack   = wr_grant;
          rd_valid = rd_grant;
          tick();
        end
        wr_ack   = 1'b0;
        rd_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 100 && n < 4; i++) begin
          #1;
          if (wreq_ready || rreq_ready) n++;
          tick();
        end
        wreq_valid = 1'b0;
        rreq_valid = 1'b0;
      end
    join
    chk("s2 accept count", n, 4);
    chk("s2 wr_burst_cnt", wr_burst_cnt, 2);
    chk("s2 rd_burst_cnt", rd_burst_cnt, 2);
    chk("final events drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
